// File: rtl/fractal_video_pkg.sv
// rtl/fractal_video_pkg.sv - shared 1080p60 timing defaults, pixel width and sink FSM encoding
package fractal_video_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    localparam int H_ACTIVE_DEF = 1920;
    localparam int H_FP_DEF     = 88;
    localparam int H_SYNC_DEF   = 44;
    localparam int H_BP_DEF     = 148;
    localparam int V_ACTIVE_DEF = 1080;
    localparam int V_FP_DEF     = 4;
    localparam int V_SYNC_DEF   = 5;
    localparam int V_BP_DEF     = 36;

    localparam logic [1:0] ST_SEEK   = 2'd0;
    localparam logic [1:0] ST_ALIGN  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

endpackage

// File: rtl/axis_video_out_if.sv
// rtl/axis_video_out_if.sv - pixel stream carrying frame start in tuser and end of line in tlast
interface axis_video_out_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tuser;
    logic                  tlast;

    modport master (output tdata, tvalid, tuser, tlast, input tready);
    modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - free-running raster counters with active, sync and frame-position flags
module video_timing_gen
    import fractal_video_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic clk,
    input  logic rst_n,
    output logic de_t,
    output logic hs_t,
    output logic vs_t,
    output logic sof,
    output logic eol,
    output logic last_cycle
);
    localparam logic [15:0] H_LAST    = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [15:0] V_LAST    = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [15:0] H_ACT     = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT     = 16'(V_ACTIVE);
    localparam logic [15:0] HS_START  = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END    = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS_START  = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END    = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [15:0] H_ACT_END = 16'(H_ACTIVE - 1);

    logic [15:0] h_cnt;
    logic [15:0] v_cnt;
    logic        h_wrap;
    logic        v_wrap;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_wrap ? 16'd0 : v_cnt + 16'd1;
        end else begin
            h_cnt <= h_cnt + 16'd1;
        end
    end

    assign de_t       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_t       = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign vs_t       = (v_cnt >= VS_START) && (v_cnt < VS_END);
    assign sof        = (h_cnt == 16'd0) && (v_cnt == 16'd0);
    assign eol        = (h_cnt == H_ACT_END);
    assign last_cycle = h_wrap && v_wrap;
endmodule

// File: rtl/axis_video_out.sv
// rtl/axis_video_out.sv - stream-to-raster sink: aligns frames to the timing generator, flags underflow and framing errors
module axis_video_out
    import fractal_video_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    axis_video_out_if.slave       s_axis,
    output logic [DATA_WIDTH-1:0] vid_data,
    output logic                  vid_de,
    output logic                  vid_hsync,
    output logic                  vid_vsync,
    output logic                  locked,
    output logic [15:0]           underflow_count,
    output logic [15:0]           sync_err_count
);
    logic       de_t, hs_t, vs_t, sof, eol, last_cycle;
    logic [1:0] state, state_nxt;
    logic       ready_c, accept, starve, frame_err;
    logic [15:0] uf_cnt, se_cnt;

    video_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk       (aclk),
        .rst_n     (aresetn),
        .de_t      (de_t),
        .hs_t      (hs_t),
        .vs_t      (vs_t),
        .sof       (sof),
        .eol       (eol),
        .last_cycle(last_cycle)
    );

    // SEEK drains everything except a frame start, which is held for ALIGN to release at (0,0).
    always_comb begin
        ready_c = 1'b0;
        case (state)
            ST_SEEK:   ready_c = !(s_axis.tvalid && s_axis.tuser);
            ST_LOCKED: ready_c = de_t;
            default:   ready_c = 1'b0;
        endcase
    end

    assign s_axis.tready = aresetn && ready_c;
    assign accept        = s_axis.tvalid && s_axis.tready;
    assign starve        = (state == ST_LOCKED) && de_t && !s_axis.tvalid;
    assign frame_err     = (state == ST_LOCKED) && accept &&
                           ((s_axis.tuser != sof) || (s_axis.tlast != eol));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_SEEK:   if (s_axis.tvalid && s_axis.tuser) state_nxt = ST_ALIGN;
            ST_ALIGN:  if (last_cycle) state_nxt = ST_LOCKED;
            ST_LOCKED: if (starve || frame_err) state_nxt = ST_SEEK;
            default:   state_nxt = ST_SEEK;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= ST_SEEK;
            vid_data  <= '0;
            vid_de    <= 1'b0;
            vid_hsync <= 1'b0;
            vid_vsync <= 1'b0;
            locked    <= 1'b0;
            uf_cnt    <= '0;
            se_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            vid_data  <= ((state == ST_LOCKED) && accept) ? s_axis.tdata : '0;
            vid_de    <= de_t;
            vid_hsync <= hs_t;
            vid_vsync <= vs_t;
            locked    <= (state == ST_LOCKED);
            if (starve && (uf_cnt != 16'hFFFF))
                uf_cnt <= uf_cnt + 16'd1;
            if (frame_err && (se_cnt != 16'hFFFF))
                se_cnt <= se_cnt + 16'd1;
        end
    end

    assign underflow_count = uf_cnt;
    assign sync_err_count  = se_cnt;
endmodule

// File: doc/axis_video_out.md
Name: axis_video_out

Overview:
- AXI4-Stream video sink: the consumer end of the pixel stream the fractal generator produces.
- Stream format: tuser = first pixel of frame, tlast = last pixel of line.
- Contains a free-running raster timing generator. Aligns incoming frames to it and drives pixel data plus hsync/vsync/de toward the display output path.
- Detects underflow and framing errors, counts them, and re-locks automatically.

Parameters:
- DATA_WIDTH, 8, pixel width (s_axis_tdata and vid_data)
- H_ACTIVE, 1920, active pixels per line
- H_FP, 88, horizontal front porch, in clocks
- H_SYNC, 44, hsync width, in clocks
- H_BP, 148, horizontal back porch, in clocks
- V_ACTIVE, 1080, active lines per frame
- V_FP, 4, vertical front porch, in lines
- V_SYNC, 5, vsync width, in lines
- V_BP, 36, vertical back porch, in lines

Ports:
- aclk  in  1  pixel clock; single clock domain
- aresetn  in  1  reset, asynchronous, active-low
- s_axis_tdata  in  DATA_WIDTH  pixel
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat accepted when tvalid&&tready
- s_axis_tuser  in  1  first pixel of frame
- s_axis_tlast  in  1  last pixel of line
- vid_data  out  DATA_WIDTH  pixel out; 0 when vid_de=0
- vid_de  out  1  active video
- vid_hsync  out  1  active-high hsync
- vid_vsync  out  1  active-high vsync
- locked  out  1  high while in LOCKED state
- underflow_count  out  16  saturating count of starved active pixels
- sync_err_count  out  16  saturating count of tuser/tlast mismatches

Behaviour:
- Reset (async assert, sync release): h_cnt=v_cnt=0, state=SEEK, all outputs 0, both counters 0. Reset mid-frame abandons the frame; no partial output after release.
- Timing counters:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL defined likewise.
  - h_cnt increments every clock and wraps at H_TOTAL-1. v_cnt increments on the h wrap and wraps at V_TOTAL-1. Both are 16-bit.
  - de_t = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hs_t = H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. vs_t is analogous, on v_cnt.
  - Counters free-run regardless of stream state.
- Output latency: vid_* are registered. Values in cycle n+1 reflect the counters and the accepted beat of cycle n.
- FSM states: SEEK, ALIGN, LOCKED.
  - SEEK: tready = !(tvalid && tuser), so beats are discarded until a frame start. A beat with tvalid&&tuser is held (not consumed) and the FSM moves to ALIGN.
  - ALIGN: tready=0. When h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1, move to LOCKED; the next cycle is raster (0,0).
  - LOCKED: tready = de_t; vid_data = accepted tdata.
- Starved active pixel (LOCKED, de_t, !tvalid):
  - vid_data=0 for that pixel.
  - underflow_count+1 (saturating at 0xFFFF).
  - Next state SEEK; vid_de/hsync/vsync continue unchanged.
- Framing check on each accepted beat in LOCKED:
  - Required: tuser == (h_cnt==0 && v_cnt==0) and tlast == (h_cnt==H_ACTIVE-1).
  - On mismatch: the beat is still displayed, sync_err_count+1 (saturating), next state SEEK.
  - Underflow and mismatch cannot coincide, since a mismatch requires tvalid.
- Blanking: tready=0 in LOCKED, so the upstream stream stalls.
- locked = (state==LOCKED), registered alongside vid_*.

Decomposition:
- Shared package fractal_video_pkg holds:
  - the 1080p60 timing constants (active, porch and sync values above);
  - the DATA_WIDTH default;
  - the FSM state enum.
- Sub-module video_timing_gen: h/v counters producing de_t, hs_t, vs_t, sof (h=v=0), eol (h=H_ACTIVE-1) and last_cycle (frame wrap). The top module holds the FSM, checks, counters and output registers.

Test Plan:
All scenarios use a reduced config: H_ACTIVE=4, H_FP=H_SYNC=H_BP=1 (H_TOTAL=7); V_ACTIVE=3, V_FP=V_SYNC=V_BP=1 (V_TOTAL=6); 42-clock frame.
1. Well-formed frames, 12 beats each with correct tuser/tlast, tvalid always 1:
   - locked=1 from the 2nd frame on; vid_data matches the beat sequence;
   - vid_de high for 4 of every 7 clocks, on lines 0-2;
   - hsync at h=5, vsync on line 4; both error counters stay 0.
2. Three junk beats (tuser=0) before the first frame start: all three are consumed and dropped, and the first displayed pixel is the tuser beat at raster (0,0).
3. tvalid dropped for one cycle at frame pixel 6:
   - vid_data=0 at that pixel; underflow_count=1; locked falls;
   - relocks at the following frame start, displaying it correctly.
4. tlast asserted early (on the 3rd beat of line 1): sync_err_count=1, the beat is still shown, state goes SEEK, and relock follows.
5. Assert aresetn=0 mid-line 1 for 3 clocks:
   - all outputs and counters read 0 asynchronously;
   - after release, locked=0 until the next frame wrap following a tuser beat.
6. Force 0xFFFF underflows (tvalid=0 permanently after lock and re-feed of tuser beats): underflow_count saturates at 0xFFFF and does not wrap.
